// File: rtl/keynsham_dbus_master.sv
// Data-side bus master: turns one CPU byte/half/word load/store into a single
// word-addressed keynsham bus access with byte lanes, replication and extraction.
module keynsham_dbus_master #(
    parameter int unsigned timeout_cycles = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_wr,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] rdata,
    output logic        d_access,
    output logic [29:0] d_addr,
    output logic [3:0]  d_bytesel,
    output logic [31:0] d_wr_val,
    output logic        d_wr_en,
    input  logic [31:0] d_data,
    input  logic        d_ack
);
    // States: IDLE accept | ISSUE one-cycle strobe | WAIT ack or timeout | DONE result | ERR failure
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

    localparam logic [7:0] CNT_LAST = 8'(timeout_cycles - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_signed;
    logic        r_wr;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [31:0] r_rdata;
    logic        r_d_access;
    logic [29:0] r_d_addr;
    logic [3:0]  r_d_bytesel;
    logic [31:0] r_d_wr_val;
    logic        r_d_wr_en;

    logic        w_bad_size;
    logic        w_misaligned;
    logic        w_timeout;
    logic [3:0]  w_bytesel;
    logic [31:0] w_wr_val;
    logic [15:0] w_shifted;
    logic [31:0] w_load_val;

    assign w_bad_size   = (req_size == 2'b11);
    assign w_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                          (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign w_timeout    = (r_cnt == CNT_LAST);
    assign w_shifted    = 16'(d_data >> {r_off, 3'b000});

    always_comb begin
        w_bytesel = 4'b1111;
        w_wr_val  = req_wdata;
        case (req_size)
            2'b00: begin
                w_bytesel = 4'b0001 << req_addr[1:0];
                w_wr_val  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_bytesel = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wr_val  = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Word loads are always aligned, so they take d_data unshifted and ignore r_signed.
    always_comb begin
        w_load_val = d_data;
        case (r_size)
            2'b00:   w_load_val = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_val = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_size      <= '0;
            r_off       <= '0;
            r_signed    <= 1'b0;
            r_wr        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
            r_rdata     <= '0;
            r_d_access  <= 1'b0;
            r_d_addr    <= '0;
            r_d_bytesel <= '0;
            r_d_wr_val  <= '0;
            r_d_wr_en   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_rdata    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        if (w_bad_size || w_misaligned) begin
                            r_done     <= 1'b1;
                            r_err      <= 1'b1;
                            r_err_code <= w_bad_size ? 2'b11 : 2'b01;
                            r_state    <= S_ERR;
                        end else begin
                            r_d_addr    <= req_addr[31:2];
                            r_d_bytesel <= w_bytesel;
                            r_d_wr_val  <= w_wr_val;
                            r_d_wr_en   <= req_wr;
                            r_d_access  <= 1'b1;
                            r_wr        <= req_wr;
                            r_signed    <= req_signed;
                            r_size      <= req_size;
                            r_off       <= req_addr[1:0];
                            r_busy      <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    r_d_access <= 1'b0;
                    r_d_wr_en  <= 1'b0;
                    if (d_ack) begin
                        r_rdata <= r_wr ? '0 : w_load_val;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_state == S_ISSUE) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else if (w_timeout) begin
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_code <= 2'b10;
                        r_busy     <= 1'b0;
                        r_state    <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign rdata     = r_rdata;
    assign d_access  = r_d_access;
    assign d_addr    = r_d_addr;
    assign d_bytesel = r_d_bytesel;
    assign d_wr_val  = r_d_wr_val;
    assign d_wr_en   = r_d_wr_en;
endmodule
